if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end that drives the 64-bit instruction ROM and queues what it returns for decode.
- Holds the PC and generates the ROM chip-enable and byte address; the ROM read is combinational, so the instruction comes back in the same cycle.
- Captures {pc, inst} pairs into a small FIFO that decode drains through a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes queued work and restarts fetch at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, fetch FIFO entries (power of 2, at least 2)
PC_STEP, 8, byte increment per instruction (64-bit instructions)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rom_ce  out  1  ROM chip enable, registered
rom_addr  out  32  ROM byte address, equals the PC register
rom_inst  in  64  ROM read data, combinational from rom_addr/rom_ce
out_valid  out  1  head entry is valid
out_ready  in  1  decode accepts the head entry
out_pc  out  32  PC of the head entry
out_inst  out  64  instruction of the head entry
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  restart address

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, rom_ce=0, FIFO empty, count=0.
  - out_valid=0, out_pc=0, out_inst=0.
- rom_ce goes to 1 on the first clock edge after rst deasserts and stays 1 until the next reset.
- rom_addr = pc at all times.
- pop = out_valid & out_ready.
- fetch = rom_ce & ~redirect_valid & (count<DEPTH | pop).
  - On fetch: write {pc, rom_inst} at the tail and set pc <= pc + PC_STEP.
  - PC arithmetic is modulo 2^32: 32'hFFFF_FFF8 wraps to 0.
- FIFO storage:
  - Registers with head and tail pointers and count, each of width log2(DEPTH)+1.
  - out_valid = (count != 0).
  - out_pc and out_inst come from the head entry through a combinational read.
  - When out_valid=0, out_pc and out_inst are 0.
- Simultaneous push and pop:
  - count is unchanged.
  - Pushing while full is legal only together with a pop.
- Latency: PC presented in cycle N gives out_valid=1 with that PC in cycle N+1 when the FIFO was empty.
- Throughput: one instruction per cycle while out_ready=1.
- Backpressure (out_ready=0):
  - The FIFO fills to DEPTH, then fetch stops and pc holds.
  - The head entry stays stable: out_pc and out_inst do not change while out_valid=1 and out_ready=0.
- Redirect (highest priority):
  - When redirect_valid=1 at an edge: FIFO cleared (count=0, pointers=0), pc <= redirect_pc, no push.
  - A pop in the same cycle is still taken by decode, but the entry is discarded.
  - out_valid=0 in the following cycle.
  - The first instruction from redirect_pc appears one cycle after that.
- Back-to-back redirects: the last one wins and no entries are pushed in between.
- Reset mid-operation: all state returns to reset values immediately, regardless of the clock.
- rom_ce=0 (only after reset): no pushes occur and rom_inst is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output port out_misalign (1 bit), stored per FIFO entry.
  - A redirect to a target with redirect_pc[2:0] != 0 loads pc with the low 3 bits cleared.
  - The first entry fetched after that redirect carries out_misalign=1; all other entries carry 0.
  - out_misalign=0 when out_valid=0 and on reset.
- Not defined:
  - No out_misalign port.
  - pc is loaded with redirect_pc unmodified.

Test Plan:
1. Reset release with RESET_PC=0 and out_ready=1 held → rom_ce=1 one edge after release; out_pc sequence 0x0, 0x8, 0x10; out_inst matches the ROM words at indices 0, 1, 2; one entry per cycle.
2. out_ready=0 for 5 cycles starting with an empty FIFO → count reaches 2; pc stops at 0x10; head stays out_pc=0x0 unchanged; out_ready=1 then drains 0x0, 0x8, 0x10 in order with no gaps.
3. Full FIFO with out_ready=1 → push and pop in the same cycle; count stays 2; no entry lost or duplicated across 10 cycles.
4. redirect_valid=1, redirect_pc=0x40, with the FIFO holding 2 entries → next cycle out_valid=0 and rom_addr=0x40; the following cycle out_pc=0x40 with out_inst equal to ROM word 8.
5. rst pulsed low mid-stream between clock edges → outputs go to reset values immediately; after release, fetch restarts at RESET_PC.
6. With FETCH_ALIGN_CHECK_EN: redirect_pc=0x44 → out_pc=0x40 with out_misalign=1; the next entry, 0x48, has out_misalign=0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch front end: drives the 64-bit instruction ROM and queues {pc, inst} pairs for decode.
// Optional macro FETCH_ALIGN_CHECK_EN adds out_misalign and aligns misaligned redirect targets.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] PC_STEP  = 32'd8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [63:0] rom_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [63:0] out_inst,
    input  logic        redirect_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    input  logic [31:0] redirect_pc,
    output logic        out_misalign
`else
    input  logic [31:0] redirect_pc
`endif
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             PW       = AW + 1;
    localparam logic [PW-1:0]  DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]  PTR_ZERO = PW'(0);

    function automatic logic [31:0] redirect_target(input logic [31:0] target);
`ifdef FETCH_ALIGN_CHECK_EN
        return {target[31:3], 3'b000};
`else
        return target;
`endif
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic          rom_ce_q, rom_ce_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   pc_mem_d   [DEPTH];
    logic [63:0]   inst_mem_q [DEPTH];
    logic [63:0]   inst_mem_d [DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
    logic          mis_mem_q  [DEPTH];
    logic          mis_mem_d  [DEPTH];
    logic          mis_pend_q, mis_pend_d;
`endif

    logic          out_valid_s;
    logic          pop_s;
    logic          fetch_s;
    logic [AW-1:0] head_idx_s;
    logic [AW-1:0] tail_idx_s;

    // Handshake decode: a push may reuse the slot freed by a same-cycle pop.
    always_comb begin
        out_valid_s = (count_q != PTR_ZERO);
        pop_s       = out_valid_s & out_ready;
        fetch_s     = rom_ce_q & ~redirect_valid & ((count_q < DEPTH_C) | pop_s);
        head_idx_s  = head_q[AW-1:0];
        tail_idx_s  = tail_q[AW-1:0];
    end

    // Next-state for PC, pointers, count and FIFO storage; redirect overrides everything.
    always_comb begin
        pc_d       = pc_q;
        rom_ce_d   = 1'b1;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
`ifdef FETCH_ALIGN_CHECK_EN
        mis_mem_d  = mis_mem_q;
        mis_pend_d = mis_pend_q;
`endif
        if (redirect_valid) begin
            pc_d    = redirect_target(redirect_pc);
            head_d  = PTR_ZERO;
            tail_d  = PTR_ZERO;
            count_d = PTR_ZERO;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_pend_d = |redirect_pc[2:0];
`endif
        end else begin
            if (fetch_s) begin
                pc_mem_d[tail_idx_s]   = pc_q;
                inst_mem_d[tail_idx_s] = rom_inst;
                tail_d                 = tail_q + PTR_ONE;
                pc_d                   = pc_q + PC_STEP;
`ifdef FETCH_ALIGN_CHECK_EN
                mis_mem_d[tail_idx_s]  = mis_pend_q;
                mis_pend_d             = 1'b0;
`endif
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({fetch_s, pop_s})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears the queue and parks the PC at RESET_PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rom_ce_q <= 1'b0;
            head_q   <= PTR_ZERO;
            tail_q   <= PTR_ZERO;
            count_q  <= PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= 32'h0000_0000;
                inst_mem_q[i] <= 64'h0000_0000_0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
                mis_mem_q[i]  <= 1'b0;
`endif
            end
`ifdef FETCH_ALIGN_CHECK_EN
            mis_pend_q <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            rom_ce_q   <= rom_ce_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_mem_q  <= mis_mem_d;
            mis_pend_q <= mis_pend_d;
`endif
        end
    end

    // Head entry is presented combinationally and forced to zero when the queue is empty.
    always_comb begin
        rom_ce    = rom_ce_q;
        rom_addr  = pc_q;
        out_valid = out_valid_s;
        if (out_valid_s) begin
            out_pc   = pc_mem_q[head_idx_s];
            out_inst = inst_mem_q[head_idx_s];
        end else begin
            out_pc   = 32'h0000_0000;
            out_inst = 64'h0000_0000_0000_0000;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        if (out_valid_s) begin
            out_misalign = mis_mem_q[head_idx_s];
        end else begin
            out_misalign = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch with a combinational ROM model.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [63:0] rom_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [63:0] out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        out_misalign;
`endif

    int checks;
    int errors;

    if_fetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH(2),
        .PC_STEP(32'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rom_ce(rom_ce),
        .rom_addr(rom_addr),
        .rom_inst(rom_inst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .redirect_valid(redirect_valid),
`ifdef FETCH_ALIGN_CHECK_EN
        .redirect_pc(redirect_pc),
        .out_misalign(out_misalign)
`else
        .redirect_pc(redirect_pc)
`endif
    );

    function automatic logic [63:0] rom_word(input logic [31:0] idx);
        return {32'hC0DE_0000 ^ idx, ~idx};
    endfunction

    assign rom_inst = rom_ce ? rom_word(rom_addr >> 3) : 64'hDEAD_BEEF_DEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_rom_ce: got %b expected 0", rom_ce); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        checks++; if (out_inst !== 64'h0) begin errors++; $display("FAIL reset_out_inst: got %h expected 0", out_inst); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", out_misalign); end
`endif
        rst = 1'b1;
        step();
        checks++; if (rom_ce !== 1'b1) begin errors++; $display("FAIL release_rom_ce: got %b expected 1", rom_ce); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_no_push: got %b expected 0", out_valid); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_pc !== 32'(i * 8)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, 32'(i * 8)); end
            checks++; if (out_inst !== rom_word(32'(i))) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, out_inst, rom_word(32'(i))); end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #3 rst = 1'b1;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr;
        out_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            exp_addr = (c == 0) ? 32'h8 : 32'h10;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
            checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc[%0d]: got %h expected 0", c, out_pc); end
            checks++; if (out_inst !== rom_word(32'h0)) begin errors++; $display("FAIL bp_head_inst[%0d]: got %h expected %h", c, out_inst, rom_word(32'h0)); end
            checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected %h", c, rom_addr, exp_addr); end
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (out_pc !== 32'(k * 8)) begin errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", k, out_pc, 32'(k * 8)); end
        end
    endtask

    task automatic test_full_stream();
        logic [31:0] exp_pc;
        exp_pc = 32'h18;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL full_pc[%0d]: got %h expected %h", c, out_pc, exp_pc); end
            checks++; if (out_inst !== rom_word(exp_pc >> 3)) begin errors++; $display("FAIL full_inst[%0d]: got %h expected %h", c, out_inst, rom_word(exp_pc >> 3)); end
            checks++; if (rom_addr !== exp_pc + 32'h10) begin errors++; $display("FAIL full_count[%0d]: rom_addr %h expected %h", c, rom_addr, exp_pc + 32'h10); end
            exp_pc = exp_pc + 32'h8;
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL redir_flush_pc: got %h expected 0", out_pc); end
        checks++; if (rom_addr !== 32'h40) begin errors++; $display("FAIL redir_rom_addr: got %h expected 40", rom_addr); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_first_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL redir_first_pc: got %h expected 40", out_pc); end
        checks++; if (out_inst !== rom_word(32'h8)) begin errors++; $display("FAIL redir_first_inst: got %h expected %h", out_inst, rom_word(32'h8)); end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid0: got %b expected 0", out_valid); end
        checks++; if (rom_addr !== 32'h100) begin errors++; $display("FAIL b2b_addr0: got %h expected 100", rom_addr); end
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid1: got %b expected 0", out_valid); end
        checks++; if (rom_addr !== 32'h200) begin errors++; $display("FAIL b2b_addr1: got %h expected 200", rom_addr); end
        step();
        checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL b2b_winner: got %h expected 200", out_pc); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step();
        checks++; if (out_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_last_pc: got %h expected fffffff8", out_pc); end
        checks++; if (out_inst !== rom_word(32'h1FFF_FFFF)) begin errors++; $display("FAIL wrap_last_inst: got %h expected %h", out_inst, rom_word(32'h1FFF_FFFF)); end
        step();
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL wrap_zero_pc: got %h expected 0", out_pc); end
        checks++; if (out_inst !== rom_word(32'h0)) begin errors++; $display("FAIL wrap_zero_inst: got %h expected %h", out_inst, rom_word(32'h0)); end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL midrst_rom_ce: got %b expected 0", rom_ce); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h expected 0", out_pc); end
        checks++; if (out_inst !== 64'h0) begin errors++; $display("FAIL midrst_inst: got %h expected 0", out_inst); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h expected 0", rom_addr); end
        #2 rst = 1'b1;
        step();
        checks++; if (rom_ce !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_release: rom_ce %b valid %b expected 1 0", rom_ce, out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL midrst_restart: valid %b pc %h expected 1 0", out_valid, out_pc); end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc = 32'h44;
        step();
        redirect_valid = 1'b0;
        checks++; if (rom_addr !== 32'h40) begin errors++; $display("FAIL mis_aligned_pc: got %h expected 40", rom_addr); end
        checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL mis_empty: got %b expected 0", out_misalign); end
        step();
        checks++; if (out_pc !== 32'h40 || out_misalign !== 1'b1) begin errors++; $display("FAIL mis_first: pc %h mis %b expected 40 1", out_pc, out_misalign); end
        step();
        checks++; if (out_pc !== 32'h48 || out_misalign !== 1'b0) begin errors++; $display("FAIL mis_second: pc %h mis %b expected 48 0", out_pc, out_misalign); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_stream();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
`ifdef FETCH_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
